// File: rtl/cus19_alu_issue.sv
// In-order ALU issue pipeline: instruction queue -> execute register -> writeback register.
// Optional build macro CUS19_DIV0_TRAP_EN traps DIV (funct 4'b0011) with op2 == 0 before it reaches the ALU.
module cus19_alu_issue #(
  parameter int Data_Width   = 8,
  parameter int Result_Width = 2 * Data_Width,
  parameter int Q_Depth      = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    flush_in,
  input  logic                    dec_valid_in,
  output logic                    dec_ready_out,
  input  logic [Data_Width-1:0]   dec_op1_in,
  input  logic [Data_Width-1:0]   dec_op2_in,
  input  logic [3:0]              dec_funct_in,
  input  logic [2:0]              dec_rd_in,
  output logic [Data_Width-1:0]   alu_op1_out,
  output logic [Data_Width-1:0]   alu_op2_out,
  output logic [3:0]              alu_funct_out,
  output logic                    alu_en_out,
  input  logic [Result_Width-1:0] alu_result_in,
  output logic                    wb_valid_out,
  input  logic                    wb_ready_in,
  output logic [Result_Width-1:0] wb_result_out,
  output logic [2:0]              wb_rd_out,
  output logic                    wb_err_out
);

  localparam int Ptr_W = $clog2(Q_Depth);
  localparam int Cnt_W = Ptr_W + 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and the producer holds its payload until the transfer.

  logic [Data_Width-1:0] q_op1   [Q_Depth];
  logic [Data_Width-1:0] q_op2   [Q_Depth];
  logic [3:0]            q_funct [Q_Depth];
  logic [2:0]            q_rd    [Q_Depth];

  logic [Ptr_W-1:0]      wr_ptr;
  logic [Ptr_W-1:0]      rd_ptr;
  logic [Cnt_W-1:0]      q_count;
  logic [Cnt_W-1:0]      count_next;

  logic                  ex_valid;
  logic [Data_Width-1:0] ex_op1;
  logic [Data_Width-1:0] ex_op2;
  logic [3:0]            ex_funct;
  logic [2:0]            ex_rd;
  logic                  ex_trap;

  logic                  push;
  logic                  pop;
  logic                  ex_adv;

  assign push   = dec_valid_in && dec_ready_out && !flush_in;
  assign ex_adv = ex_valid && (!wb_valid_out || wb_ready_in);
  assign pop    = (q_count != '0) && (!ex_valid || ex_adv);

`ifdef CUS19_DIV0_TRAP_EN
  assign ex_trap = ex_valid && (ex_funct == 4'b0011) && (ex_op2 == '0);
`else
  assign ex_trap = 1'b0;
`endif

  always_comb begin
    count_next = q_count;
    if (flush_in) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = q_count + 1'b1;
        2'b01:   count_next = q_count - 1'b1;
        default: count_next = q_count;
      endcase
    end
  end

  // Queue storage needs no reset: entries are only read when counted as valid.
  always_ff @(posedge clk_in) begin
    if (push) begin
      q_op1[wr_ptr]   <= dec_op1_in;
      q_op2[wr_ptr]   <= dec_op2_in;
      q_funct[wr_ptr] <= dec_funct_in;
      q_rd[wr_ptr]    <= dec_rd_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      q_count       <= '0;
      dec_ready_out <= 1'b0;
    end else begin
      q_count       <= count_next;
      dec_ready_out <= !flush_in && (count_next < Cnt_W'(Q_Depth));
      if (flush_in) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ex_valid <= 1'b0;
      ex_op1   <= '0;
      ex_op2   <= '0;
      ex_funct <= '0;
      ex_rd    <= '0;
    end else if (flush_in) begin
      ex_valid <= 1'b0;
    end else if (pop) begin
      ex_valid <= 1'b1;
      ex_op1   <= q_op1[rd_ptr];
      ex_op2   <= q_op2[rd_ptr];
      ex_funct <= q_funct[rd_ptr];
      ex_rd    <= q_rd[rd_ptr];
    end else if (ex_adv) begin
      ex_valid <= 1'b0;
    end
  end

  assign alu_en_out    = ex_valid && !ex_trap;
  assign alu_op1_out   = ex_valid ? ex_op1   : '0;
  assign alu_op2_out   = ex_valid ? ex_op2   : '0;
  assign alu_funct_out = ex_valid ? ex_funct : '0;

  // A trapped entry bypasses the ALU and writes back an all-ones result.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wb_valid_out  <= 1'b0;
      wb_result_out <= '0;
      wb_rd_out     <= '0;
    end else if (flush_in) begin
      wb_valid_out <= 1'b0;
    end else if (ex_adv) begin
      wb_valid_out  <= 1'b1;
      wb_result_out <= ex_trap ? '1 : alu_result_in;
      wb_rd_out     <= ex_rd;
    end else if (wb_ready_in) begin
      wb_valid_out <= 1'b0;
    end
  end

`ifdef CUS19_DIV0_TRAP_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wb_err_out <= 1'b0;
    end else if (!flush_in && ex_adv) begin
      wb_err_out <= ex_trap;
    end
  end
`else
  assign wb_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_cus19_alu_issue.sv
// Self-checking bench for cus19_alu_issue with a behavioural ALU and an in-order scoreboard.
module tb_cus19_alu_issue;

  localparam int DW = 8;
  localparam int RW = 16;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          dec_valid;
  logic          dec_ready;
  logic [DW-1:0] dec_op1, dec_op2;
  logic [3:0]    dec_funct;
  logic [2:0]    dec_rd;
  logic [DW-1:0] alu_op1, alu_op2;
  logic [3:0]    alu_funct;
  logic          alu_en;
  logic [RW-1:0] alu_result;
  logic          wb_valid;
  logic          wb_ready;
  logic [RW-1:0] wb_result;
  logic [2:0]    wb_rd;
  logic          wb_err;

  int            n_checks = 0;
  int            n_pass   = 0;
  int            cyc      = 0;
  bit            rand_bp  = 1'b0;
  logic [19:0]   exp_q[$];
  logic [RW-1:0] got_q[$];
  int            pop_cyc[$];
  logic [19:0]   ent;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  cus19_alu_issue #(.Data_Width(DW), .Result_Width(RW), .Q_Depth(QD)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush),
    .dec_valid_in(dec_valid), .dec_ready_out(dec_ready),
    .dec_op1_in(dec_op1), .dec_op2_in(dec_op2), .dec_funct_in(dec_funct), .dec_rd_in(dec_rd),
    .alu_op1_out(alu_op1), .alu_op2_out(alu_op2), .alu_funct_out(alu_funct), .alu_en_out(alu_en),
    .alu_result_in(alu_result),
    .wb_valid_out(wb_valid), .wb_ready_in(wb_ready), .wb_result_out(wb_result),
    .wb_rd_out(wb_rd), .wb_err_out(wb_err)
  );

  // Reference ALU; divide-by-zero yields a recognisable marker value.
  function automatic logic [RW-1:0] alu_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [3:0] f);
    logic [RW-1:0] ax, bx;
    ax = RW'(a);
    bx = RW'(b);
    case (f)
      4'd0:    return ax + bx;
      4'd1:    return ax - bx;
      4'd2:    return ax * bx;
      4'd3:    return (b == '0) ? 16'hBEEF : ax / bx;
      4'd4:    return ax & bx;
      4'd5:    return ax | bx;
      4'd6:    return ax ^ bx;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_model(alu_op1, alu_op2, alu_funct);

  function automatic logic [19:0] expect_of(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [3:0] f, input logic [2:0] rd);
`ifdef CUS19_DIV0_TRAP_EN
    if (f == 4'd3 && b == '0) return {rd, 1'b1, 16'hFFFF};
`endif
    return {rd, 1'b0, alu_model(a, b, f)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard: every writeback handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        ent = exp_q.pop_front();
        check("wb_result", 32'(wb_result), 32'(ent[15:0]));
        check("wb_rd",     32'(wb_rd),     32'(ent[19:17]));
        check("wb_err",    32'(wb_err),    32'(ent[16]));
        got_q.push_back(wb_result);
        pop_cyc.push_back(cyc);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_bp) wb_ready = ($urandom_range(0, 3) != 0);
  end

  // Returns 1 ns after the accepting edge.
  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] f,
                      input logic [2:0] rd);
    int waited;
    waited    = 0;
    dec_op1   = a;
    dec_op2   = b;
    dec_funct = f;
    dec_rd    = rd;
    dec_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (dec_ready) break;
      waited++;
      if (waited > 200) break;
    end
    if (waited > 200) begin
      check("push_timeout", 32'(waited), 32'd0);
      dec_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      dec_valid = 1'b0;
      exp_q.push_back(expect_of(a, b, f, rd));
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !wb_valid) break;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; dec_valid = 1'b0; wb_ready = 1'b1;
    dec_op1 = '0; dec_op2 = '0; dec_funct = '0; dec_rd = '0;
    #1;
    check("rst_ready",  32'(dec_ready), 32'd0);
    check("rst_wbv",    32'(wb_valid),  32'd0);
    check("rst_wbres",  32'(wb_result), 32'd0);
    check("rst_alu_en", 32'(alu_en),    32'd0);
    check("rst_alu_op", 32'({alu_op1, alu_op2, alu_funct}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(dec_ready), 32'd0);
    step();
    check("ready_first_edge", 32'(dec_ready), 32'd1);

    // Single ADD, latency 2
    push(8'd15, 8'd10, 4'd0, 3'd2);
    check("add_ex_idle", 32'(alu_en), 32'd0);
    step();
    check("add_alu_en",  32'(alu_en), 32'd1);
    check("add_alu_ops", 32'({alu_op1, alu_op2, alu_funct}), 32'({8'd15, 8'd10, 4'd0}));
    check("add_wb_early", 32'(wb_valid), 32'd0);
    step();
    check("add_wbv",  32'(wb_valid),  32'd1);
    check("add_res",  32'(wb_result), 32'd25);
    check("add_rd",   32'(wb_rd),     32'd2);
    wait_drain();

    // Back-to-back stream
    got_q.delete(); pop_cyc.delete();
    push(8'd20, 8'd5, 4'd1, 3'd1);
    push(8'd12, 8'd3, 4'd2, 3'd2);
    push(8'hF0, 8'h0F, 4'd4, 3'd3);
    wait_drain();
    check("stream_cnt", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check("stream_r0", 32'(got_q[0]), 32'd15);
      check("stream_r1", 32'(got_q[1]), 32'd36);
      check("stream_r2", 32'(got_q[2]), 32'd0);
      check("stream_gap01", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
      check("stream_gap12", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
    end

    // Backpressure: six accepts fill Q, EX and WB
    got_q.delete();
    wb_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push(8'(i + 1), 8'd2, 4'd0, 3'(i));
      if (i == 4) check("bp_ready_5", 32'(dec_ready), 32'd1);
    end
    check("bp_ready_6", 32'(dec_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_v",   32'(wb_valid),  32'd1);
      check("bp_hold_res", 32'(wb_result), 32'd3);
      check("bp_hold_rd",  32'(wb_rd),     32'd0);
      check("bp_stay_full", 32'(dec_ready), 32'd0);
    end
    wb_ready = 1'b1;
    wait_drain();
    check("bp_drained", 32'(got_q.size()), 32'd6);

    // Flush with everything full
    wb_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(10 + i), 8'd1, 4'd5, 3'(i));
    dec_op1 = 8'd99; dec_op2 = 8'd1; dec_funct = 4'd0; dec_rd = 3'd7;
    dec_valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    dec_valid = 1'b0;
    exp_q.delete();
    check("flush_count",  32'(dut.q_count), 32'd0);
    check("flush_wbv",    32'(wb_valid),    32'd0);
    check("flush_alu_en", 32'(alu_en),      32'd0);
    step();
    check("flush_ready_back", 32'(dec_ready), 32'd1);
    check("flush_no_accept",  32'(dut.q_count), 32'd0);
    wb_ready = 1'b1;
    got_q.delete();
    push(8'd7, 8'd8, 4'd0, 3'd4);
    wait_drain();
    check("flush_fresh_cnt", 32'(got_q.size()), 32'd1);

    // Reset mid-stream
    wb_ready = 1'b0;
    push(8'd3, 8'd3, 4'd2, 3'd1);
    push(8'd4, 8'd4, 4'd2, 3'd2);
    push(8'd5, 8'd5, 4'd2, 3'd3);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mrst_wbv",    32'(wb_valid),  32'd0);
    check("mrst_wb",     32'({wb_result, wb_rd, wb_err}), 32'd0);
    check("mrst_ready",  32'(dec_ready), 32'd0);
    check("mrst_alu",    32'({alu_en, alu_op1, alu_op2, alu_funct}), 32'd0);
    check("mrst_count",  32'(dut.q_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wb_ready = 1'b1;
    push(8'd9, 8'd4, 4'd2, 3'd5);
    step();
    check("mrst_lat_k1", 32'(wb_valid), 32'd0);
    step();
    check("mrst_lat_k2", 32'(wb_valid),  32'd1);
    check("mrst_res",    32'(wb_result), 32'd36);
    wait_drain();

    // Divide, including divide-by-zero
    push(8'd100, 8'd7, 4'd3, 3'd1);
    step(); step();
    check("div_res", 32'(wb_result), 32'd14);
    wait_drain();
    push(8'd22, 8'd0, 4'd3, 3'd6);
    step();
`ifdef CUS19_DIV0_TRAP_EN
    check("div0_alu_en", 32'(alu_en), 32'd0);
`else
    check("div0_alu_en", 32'(alu_en), 32'd1);
`endif
    step();
    check("div0_wbv", 32'(wb_valid), 32'd1);
`ifdef CUS19_DIV0_TRAP_EN
    check("div0_res", 32'(wb_result), 32'hFFFF);
    check("div0_err", 32'(wb_err),    32'd1);
`else
    check("div0_res", 32'(wb_result), 32'hBEEF);
    check("div0_err", 32'(wb_err),    32'd0);
`endif
    wait_drain();

    // Random traffic with random writeback backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 15)),
           4'($urandom_range(0, 6)), 3'($urandom_range(0, 7)));
    end
    rand_bp = 1'b0;
    #2;
    wb_ready = 1'b1;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
